// File: rtl/rgmii_inband_status_decoder_if.sv
// GMII-side receive bus and committed in-band status bundle
// for rgmii_inband_status_decoder.
interface rgmii_inband_status_decoder_if;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic       inband_link_status;
  logic [1:0] inband_clock_speed;
  logic       inband_duplex_status;
  logic       status_change;

  modport master (
    output gmii_rxd, gmii_rx_dv, gmii_rx_er,
    input  inband_link_status, inband_clock_speed,
    input  inband_duplex_status, status_change
  );

  modport slave (
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
    output inband_link_status, inband_clock_speed,
    output inband_duplex_status, status_change
  );
endinterface

// File: rtl/rgmii_inband_status_decoder.sv
// RGMII in-band status decode with IFG qualify and debounce.
// Optional macro INBAND_NIBBLE_CHECK_EN: require rxd[7:4]==rxd[3:0].
module rgmii_inband_status_decoder #(
  parameter int STABLE_CNT = 4,
  parameter int IFG_SKIP   = 2
) (
  input logic rx_mac_aclk,
  input logic sys_rst,
  rgmii_inband_status_decoder_if.slave gmii
);

  localparam logic [7:0] STC  = 8'(STABLE_CNT);
  localparam logic [3:0] SKIP = 4'(IFG_SKIP);

  logic [7:0] s1_rxd;
  logic       s1_dv;
  logic       s1_er;
  logic [3:0] ifg_cnt;
  logic [7:0] stable_cnt;
  logic [3:0] cand;
  logic       cand_ok;
  logic [3:0] stat;
  logic       chg;

  logic       busy;
  logic       qual;
  logic [3:0] smp;
  logic       smp_ok;
  logic       match;
  logic [7:0] nxt_cnt;
  logic       reach;

  always_comb begin
    busy = s1_dv | s1_er;
    qual = !busy && (ifg_cnt >= SKIP);
    smp  = s1_rxd[3:0];
`ifdef INBAND_NIBBLE_CHECK_EN
    smp_ok = (smp[2:1] != 2'b11) &&
             (s1_rxd[7:4] == s1_rxd[3:0]);
`else
    smp_ok = (smp[2:1] != 2'b11);
`endif
    match = cand_ok && (cand == smp);
    if (!match)
      nxt_cnt = 8'd1;
    else if (stable_cnt == STC)
      nxt_cnt = STC;
    else
      nxt_cnt = stable_cnt + 8'd1;
    // a saturated count seeing the same value must not re-commit
    reach = qual && smp_ok && (nxt_cnt == STC) &&
            (!match || (stable_cnt != STC));
  end

  always_ff @(posedge rx_mac_aclk or posedge sys_rst) begin
    if (sys_rst) begin
      s1_rxd     <= 8'h00;
      s1_dv      <= 1'b0;
      s1_er      <= 1'b0;
      ifg_cnt    <= 4'd0;
      stable_cnt <= 8'd0;
      cand       <= 4'd0;
      cand_ok    <= 1'b0;
      stat       <= 4'd0;
      chg        <= 1'b0;
    end else begin
      s1_rxd <= gmii.gmii_rxd;
      s1_dv  <= gmii.gmii_rx_dv;
      s1_er  <= gmii.gmii_rx_er;
      if (busy)
        ifg_cnt <= 4'd0;
      else if (ifg_cnt != 4'hF)
        ifg_cnt <= ifg_cnt + 4'd1;
      if (qual) begin
        if (!smp_ok) begin
          stable_cnt <= 8'd0;
          cand_ok    <= 1'b0;
        end else begin
          cand       <= smp;
          cand_ok    <= 1'b1;
          stable_cnt <= nxt_cnt;
        end
      end
      chg <= 1'b0;
      if (reach && (stat != smp)) begin
        stat <= smp;
        chg  <= 1'b1;
      end
    end
  end

  assign gmii.inband_link_status   = stat[0];
  assign gmii.inband_clock_speed   = stat[2:1];
  assign gmii.inband_duplex_status = stat[3];
  assign gmii.status_change        = chg;

endmodule

// File: tb/tb_rgmii_inband_status_decoder.sv
// Table-driven scoreboard bench for rgmii_inband_status_decoder
// (STABLE_CNT=4, IFG_SKIP=2).
module tb_rgmii_inband_status_decoder;

  logic rx_mac_aclk = 1'b0;
  logic sys_rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 rx_mac_aclk = ~rx_mac_aclk;

  rgmii_inband_status_decoder_if bus ();

  rgmii_inband_status_decoder #(
    .STABLE_CNT (4),
    .IFG_SKIP   (2)
  ) dut (
    .rx_mac_aclk (rx_mac_aclk),
    .sys_rst     (sys_rst),
    .gmii        (bus.slave)
  );

  typedef struct {
    logic [7:0] rxd;
    logic       dv;
    logic       er;
    logic       link;
    logic [1:0] spd;
    logic       dup;
    logic       chg;
    int         idx;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic void add(input logic [7:0] rxd,
                              input logic dv, input logic er,
                              input int n, input logic link,
                              input logic [1:0] spd,
                              input logic dup, input logic chg);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rxd  = rxd;
      v.dv   = dv;
      v.er   = er;
      v.link = link;
      v.spd  = spd;
      v.dup  = dup;
      v.chg  = chg;
      v.idx  = vecs.size();
      vecs.push_back(v);
    end
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [4:0] exp);
    logic [4:0] got;
    got = {bus.inband_link_status, bus.inband_clock_speed,
           bus.inband_duplex_status, bus.status_change};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got l/s/d/c=%b required %b",
               name, idx, got, exp);
    end
  endtask

  task automatic run(input string name);
    vec_t e;
    sb.delete();
    foreach (vecs[i]) begin
      @(negedge rx_mac_aclk);
      bus.gmii_rxd   = vecs[i].rxd;
      bus.gmii_rx_dv = vecs[i].dv;
      bus.gmii_rx_er = vecs[i].er;
      sb.push_back(vecs[i]);
      @(posedge rx_mac_aclk);
      #1;
      if (sb.size() > 1) begin
        e = sb.pop_front();
        check(name, e.idx, {e.link, e.spd, e.dup, e.chg});
      end
    end
    @(posedge rx_mac_aclk);
    #1;
    e = sb.pop_front();
    check(name, e.idx, {e.link, e.spd, e.dup, e.chg});
    vecs.delete();
  endtask

  initial begin
    bus.gmii_rxd   = 8'h00;
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rx_er = 1'b0;

    add(8'h00, 0, 0, 10, 0, 2'b00, 0, 0);
    add(8'hDD, 0, 0, 3, 0, 2'b00, 0, 0);
    add(8'hDD, 0, 0, 1, 1, 2'b10, 1, 1);
    add(8'hDD, 0, 0, 3, 1, 2'b10, 1, 0);
    add(8'h33, 0, 0, 3, 1, 2'b10, 1, 0);
    add(8'h33, 0, 0, 1, 1, 2'b01, 0, 1);
    // glitch: BB restarts the count
    add(8'hDD, 0, 0, 3, 1, 2'b01, 0, 0);
    add(8'hBB, 0, 0, 1, 1, 2'b01, 0, 0);
    add(8'hDD, 0, 0, 3, 1, 2'b01, 0, 0);
    add(8'hDD, 0, 0, 1, 1, 2'b10, 1, 1);
    add(8'hDD, 0, 0, 2, 1, 2'b10, 1, 0);
    add(8'h33, 0, 0, 3, 1, 2'b10, 1, 0);
    add(8'h33, 0, 0, 1, 1, 2'b01, 0, 1);
    // frame holds the count; two idle samples skipped after it
    add(8'hDD, 0, 0, 2, 1, 2'b01, 0, 0);
    add(8'h55, 1, 0, 20, 1, 2'b01, 0, 0);
    add(8'h55, 0, 1, 1, 1, 2'b01, 0, 0);
    add(8'hDD, 0, 0, 3, 1, 2'b01, 0, 0);
    add(8'hDD, 0, 0, 1, 1, 2'b10, 1, 1);
    add(8'hDD, 0, 0, 2, 1, 2'b10, 1, 0);
    add(8'h33, 0, 0, 3, 1, 2'b10, 1, 0);
    add(8'h33, 0, 0, 1, 1, 2'b01, 0, 1);
    // speed 11 invalidates the candidate
    add(8'hDD, 0, 0, 3, 1, 2'b01, 0, 0);
    add(8'h77, 0, 0, 1, 1, 2'b01, 0, 0);
    add(8'hDD, 0, 0, 3, 1, 2'b01, 0, 0);
    add(8'hDD, 0, 0, 1, 1, 2'b10, 1, 1);
    add(8'hDD, 0, 0, 1, 1, 2'b10, 1, 0);
    add(8'h33, 0, 0, 3, 1, 2'b10, 1, 0);
    add(8'h33, 0, 0, 1, 1, 2'b01, 0, 1);
`ifdef INBAND_NIBBLE_CHECK_EN
    add(8'h0D, 0, 0, 6, 1, 2'b01, 0, 0);
`else
    add(8'h0D, 0, 0, 3, 1, 2'b01, 0, 0);
    add(8'h0D, 0, 0, 1, 1, 2'b10, 1, 1);
    add(8'h0D, 0, 0, 2, 1, 2'b10, 1, 0);
`endif

    repeat (3) @(posedge rx_mac_aclk);
    #1;
    check("reset", 0, 5'b00000);
    sys_rst = 1'b0;
    run("main");

    // reset mid-count: two 33 samples, then reset
    repeat (2) begin
      @(negedge rx_mac_aclk);
      bus.gmii_rxd = 8'h33;
    end
    @(posedge rx_mac_aclk);
    #1;
    sys_rst = 1'b1;
    #1;
    check("mid_reset", 0, 5'b00000);
    @(posedge rx_mac_aclk);
    #1;
    check("mid_reset_hold", 0, 5'b00000);
    sys_rst = 1'b0;

    add(8'h33, 0, 0, 4, 0, 2'b00, 0, 0);
    add(8'h33, 0, 0, 1, 1, 2'b01, 0, 1);
    add(8'h33, 0, 0, 3, 1, 2'b01, 0, 0);
    run("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
